segment_reader: RTL and testbench

Decodes the two-digit active-low 7-segment pattern driven onto the HEX0 (ones) and HEX1 (tens) buses back into a 5-bit binary value in the range 0..31. It sits on the display side of the calculator datapath and serves as the readback and self-check path for the sum display. A reading is reported only after the pattern has held stable for a programmable number of cycles. Results are delivered over a valid/ready handshake, and illegal patterns are flagged.

---
 rtl/segment_reader_pkg.sv | 43 ++++
 rtl/seg_digit_decode.sv | 36 +++
 rtl/segment_reader.sv | 167 ++++++++++++++++
 tb/tb_segment_reader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/segment_reader_pkg.sv
// segment_reader_pkg: shared definitions for the 7-segment readback path.
//   - SEG_0..SEG_9 / SEG_BLANK : active-low segment codes, bits [6:0] = HEX segments 6..0
//   - state_e                  : reader FSM states (2-bit encoding)
//   - sample_t                 : one {tens, ones} display sample
//   - digits_to_value()        : tens*10 + ones in 6 bits (tens already range-limited)
package segment_reader_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_PRESENT = 2'd2,
    S_WAIT    = 2'd3
  } state_e;

  typedef struct packed {
    logic [6:0] tens;
    logic [6:0] ones;
  } sample_t;

  localparam sample_t SAMPLE_BLANK = '{tens: SEG_BLANK, ones: SEG_BLANK};

  // Only the low two tens bits are used: the caller rejects tens > 3 separately,
  // which keeps the product inside 6 bits.
  function automatic logic [5:0] digits_to_value(input logic [1:0] tens,
                                                 input logic [3:0] ones);
    logic [5:0] prod;
    prod = {4'd0, tens} * 6'd10;
    return prod + {2'd0, ones};
  endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// seg_digit_decode: combinational map from one active-low 7-segment code to a
// decimal digit.
//   code  : 7-bit segment pattern (0 = lit)
//   digit : decoded digit 0..9 (0 when not legal)
//   legal : 1 when code is one of the ten digit codes; blank is not legal
module seg_digit_decode
  import segment_reader_pkg::*;
(
  input  logic [6:0] code,
  output logic [3:0] digit,
  output logic       legal
);

  // Code-to-digit lookup; anything outside the ten digit codes is illegal.
  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (code)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: begin
        digit = 4'd0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/segment_reader.sv
// segment_reader: reads a two-digit active-low 7-segment display back into a
// binary value 0..31, reporting each stable pattern once over valid/ready.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   seg_ones, seg_tens  : HEX0 / HEX1 segment buses (0 = lit)
//   out_valid/out_ready : result handshake; data held until accepted
//   out_value           : tens*10 + ones (0 when out_err)
//   out_err             : presented pattern is not a legal 0..31 reading
// STABLE_CYCLES (1..255) is the number of unchanged samples needed after a
// change before the pattern is reported.
module segment_reader
  import segment_reader_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_ones,
  input  logic [6:0] seg_tens,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_value,
  output logic       out_err
);

  localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);

  sample_t          new_s;
  sample_t          sample_q;
  sample_t          cap_q, cap_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_run;
  logic             out_valid_q, out_valid_d;
  logic [4:0]       out_value_q, out_value_d;
  logic             out_err_q, out_err_d;

  logic             new_blank;
  logic [3:0]       tens_digit, ones_digit;
  logic             tens_legal, ones_legal;
  logic [5:0]       value6;
  logic             reading_legal;
  logic [4:0]       reading_value;

  assign new_s     = '{tens: seg_tens, ones: seg_ones};
  assign new_blank = (new_s == SAMPLE_BLANK);

  seg_digit_decode u_dec_tens (
    .code  (sample_q.tens),
    .digit (tens_digit),
    .legal (tens_legal)
  );

  seg_digit_decode u_dec_ones (
    .code  (sample_q.ones),
    .digit (ones_digit),
    .legal (ones_legal)
  );

  // Value of the held sample; range is checked on the 6-bit sum before truncation.
  always_comb begin
    value6        = digits_to_value(tens_digit[1:0], ones_digit);
    reading_legal = tens_legal & ones_legal & (tens_digit <= 4'd3) & (value6 <= 6'd31);
    reading_value = 5'd0;
    if (reading_legal) begin
      reading_value = value6[4:0];
    end else begin
      reading_value = 5'd0;
    end
  end

  // Stability count of the incoming sample against the held one, saturating.
  always_comb begin
    cnt_run = cnt_q;
    if (new_s != sample_q) begin
      cnt_run = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_run = cnt_q + CNT_W'(1);
    end else begin
      cnt_run = cnt_q;
    end
  end

  // Next-state and output logic. Transitions look at the incoming sample so
  // that a stable window of STABLE_CYCLES edges after the change is enough;
  // the capture decodes the held sample, which equals the incoming one then.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_run;
    cap_d       = cap_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_err_d   = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (new_blank) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (new_blank) begin
          state_d = S_IDLE;
        end else if (cnt_run == CNT_MAX) begin
          state_d     = S_PRESENT;
          cap_d       = sample_q;
          out_valid_d = 1'b1;
          out_value_d = reading_value;
          out_err_d   = ~reading_legal;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_PRESENT: begin
        // Data is frozen here; sampling and counting carry on underneath.
        if (out_ready) begin
          state_d     = S_WAIT;
          out_valid_d = 1'b0;
        end else begin
          state_d = S_PRESENT;
        end
      end
      S_WAIT: begin
        if (new_blank) begin
          state_d = S_IDLE;
        end else if (new_s != cap_q) begin
          // A different pattern always earns a fresh full window.
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cnt_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, sample, counter, capture and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sample_q    <= SAMPLE_BLANK;
      cnt_q       <= '0;
      cap_q       <= SAMPLE_BLANK;
      out_valid_q <= 1'b0;
      out_value_q <= 5'd0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= new_s;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_segment_reader.sv
// tb_segment_reader: directed and random stimulus for segment_reader, checked
// every cycle against a run-length based reference model.
module tb_segment_reader;

  localparam int          SC = 4;
  localparam logic [6:0]  BL = 7'h7F;
  localparam logic [13:0] BLANK2 = {BL, BL};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] seg_ones = BL;
  logic [6:0] seg_tens = BL;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [4:0] out_value;
  logic       out_err;

  always #5 clk = ~clk;

  segment_reader #(.STABLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_ones  (seg_ones),
    .seg_tens  (seg_tens),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_err   (out_err)
  );

  logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [13:0] m_prev, m_cap;
  int          m_run;
  bit          m_pres, m_wait;
  int          m_val;
  bit          m_err;

  // observation bookkeeping
  int edge_n, pulses, first_rise, last_rise, acc_edge;
  bit prev_obs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] pat(input int t, input int o);
    return {codes[t], codes[o]};
  endfunction

  // Reading rules: both digits must be real digit codes and the value <= 31.
  task automatic ref_decode(input logic [13:0] p, output int v, output bit e);
    int t = -1;
    int o = -1;
    for (int i = 0; i < 10; i++) begin
      if (codes[i] == p[13:7]) t = i;
      if (codes[i] == p[6:0])  o = i;
    end
    if (t >= 0 && o >= 0 && (t * 10 + o) <= 31) begin
      v = t * 10 + o;
      e = 1'b0;
    end else begin
      v = 0;
      e = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_prev = BLANK2;
    m_cap  = BLANK2;
    m_run  = 1;
    m_pres = 1'b0;
    m_wait = 1'b0;
  endtask

  // One clock edge: m_run is the number of consecutive edges that sampled the
  // current pattern; a reading is due when it reaches SC+1 samples.
  task automatic model_edge(input logic [13:0] s, input bit r);
    if (s == m_prev) m_run++;
    else m_run = 1;
    m_prev = s;
    if (m_pres) begin
      if (r) begin
        m_pres = 1'b0;
        m_wait = 1'b1;
      end
    end else if (m_wait) begin
      if (s == BLANK2) begin
        m_wait = 1'b0;
      end else if (s != m_cap) begin
        m_wait = 1'b0;
        m_run  = 1;
      end
    end else if (s != BLANK2 && m_run == SC + 1) begin
      m_cap  = s;
      ref_decode(s, m_val, m_err);
      m_pres = 1'b1;
    end
  endtask

  task automatic start_test();
    edge_n     = 0;
    pulses     = 0;
    first_rise = -1;
    last_rise  = -1;
  endtask

  task automatic step(input logic [13:0] p, input bit r);
    @(negedge clk);
    seg_tens  = p[13:7];
    seg_ones  = p[6:0];
    out_ready = r;
    @(posedge clk);
    model_edge(p, r);
    edge_n++;
    #1;
    chk("valid", out_valid, m_pres);
    if (m_pres) begin
      chk("value", out_value, m_val);
      chk("err", out_err, m_err);
    end
    if (out_valid && !prev_obs) begin
      pulses++;
      last_rise = edge_n;
      if (first_rise < 0) first_rise = edge_n;
    end
    prev_obs = out_valid;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_value", out_value, 0);
    chk("rst_async_err", out_err, 0);
    seg_tens  = BL;
    seg_ones  = BL;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_valid", out_valid, 0);
      chk("rst_hold_value", out_value, 0);
      chk("rst_hold_err", out_err, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    prev_obs = 1'b0;
    start_test();
  endtask

  initial begin
    logic [13:0] p;
    int          hold, sel;
    model_reset();
    do_reset();

    // Random activity against the model.
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      p = BLANK2;
      else if (sel == 1) p = {codes[$urandom_range(0, 3)], 7'h7E};
      else if (sel == 2) p = {BL, codes[$urandom_range(0, 9)]};
      else               p = pat($urandom_range(0, 4), $urandom_range(0, 9));
      hold = $urandom_range(1, 8);
      for (int k = 0; k < hold; k++) step(p, 1'($urandom_range(0, 1)));
    end
    // Park a fresh pending reading, then reset asynchronously over it.
    step(BLANK2, 1'b1);
    for (int k = 0; k < SC + 2; k++) step(pat(2, 3), 1'b0);
    chk("pending_before_reset", out_valid, 1);
    do_reset();

    // "15" held with ready high: one pulse, 5 edges after setup.
    for (int k = 0; k < 25; k++) step(pat(1, 5), 1'b1);
    chk("t15_rise_edge", first_rise, 5);
    chk("t15_pulses", pulses, 1);

    // "15" for 4 edges, changed to "16" on the final counting edge.
    do_reset();
    for (int k = 0; k < 4; k++) step(pat(1, 5), 1'b1);
    for (int k = 0; k < 12; k++) step(pat(1, 6), 1'b1);
    chk("t16_rise_edge", first_rise, 9);
    chk("t16_pulses", pulses, 1);

    // "31" stalled by the consumer while the display moves to "7".
    do_reset();
    for (int k = 0; k < 7; k++) step(pat(3, 1), 1'b0);
    for (int k = 0; k < 8; k++) step(pat(0, 7), 1'b0);
    chk("t31_held_value", out_value, 31);
    step(pat(0, 7), 1'b1);
    acc_edge = edge_n;
    for (int k = 0; k < 10; k++) step(pat(0, 7), 1'b1);
    chk("t7_after_accept", last_rise - acc_edge, 5);
    chk("t7_pulses", pulses, 2);

    // Illegal patterns.
    do_reset();
    for (int k = 0; k < 7; k++) step({7'h40, 7'h7E}, 1'b1);
    for (int k = 0; k < 7; k++) step(pat(3, 5), 1'b1);
    for (int k = 0; k < 7; k++) step({BL, 7'h79}, 1'b1);
    chk("illegal_pulses", pulses, 3);

    // Long blank, then "0".
    do_reset();
    for (int k = 0; k < 50; k++) step(BLANK2, 1'b1);
    chk("blank_pulses", pulses, 0);
    for (int k = 0; k < 7; k++) step(pat(0, 0), 1'b1);
    chk("zero_pulses", pulses, 1);
    chk("zero_rise_edge", first_rise, 55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
